// File: rtl/alu_pkg.sv
// Shared constants for the lab-processor ALU: function-select codes and mode values.
package alu_pkg;

  localparam logic [1:0] SEL_AND  = 2'b00;
  localparam logic [1:0] SEL_OR   = 2'b01;
  localparam logic [1:0] SEL_XOR  = 2'b10;
  localparam logic [1:0] SEL_NOT  = 2'b11;

  localparam logic [1:0] SEL_XFER = 2'b00;
  localparam logic [1:0] SEL_ADD  = 2'b01;
  localparam logic [1:0] SEL_SUB  = 2'b10;
  localparam logic [1:0] SEL_DEC  = 2'b11;

  localparam logic MODE_LOGIC = 1'b0;
  localparam logic MODE_ARITH = 1'b1;

endpackage

// File: rtl/alu_ripple_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of 1-bit full adders.
module alu_ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/alu4_core.sv
// Registered ripple-carry ALU: four arithmetic (M=1) and four logic (M=0) functions,
// result and carry-out available one clock after the operands are sampled.
module alu4_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  input  logic             S1,
  input  logic             S0,
  input  logic             M,
  output logic             C_out,
  output logic [WIDTH-1:0] data_out
);

  logic [1:0]       sel;
  logic [WIDTH-1:0] y_operand;
  logic [WIDTH-1:0] sum;
  logic             sum_cout;
  logic [WIDTH-1:0] logic_result;

  assign sel = {S1, S0};

  // Second adder operand; transfer and decrement reuse the adder with a constant Y.
  always_comb begin
    y_operand = '0;
    case (sel)
      SEL_XFER: y_operand = '0;
      SEL_ADD:  y_operand = B;
      SEL_SUB:  y_operand = ~B;
      SEL_DEC:  y_operand = '1;
      default:  y_operand = '0;
    endcase
  end

  alu_ripple_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a    (A),
    .b    (y_operand),
    .cin  (C0),
    .sum  (sum),
    .cout (sum_cout)
  );

  always_comb begin
    logic_result = '0;
    case (sel)
      SEL_AND: logic_result = A & B;
      SEL_OR:  logic_result = A | B;
      SEL_XOR: logic_result = A ^ B;
      SEL_NOT: logic_result = ~A;
      default: logic_result = '0;
    endcase
  end

  // Logic mode never reports a carry, regardless of C0.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      C_out    <= 1'b0;
    end else if (M == MODE_ARITH) begin
      data_out <= sum;
      C_out    <= sum_cout;
    end else begin
      data_out <= logic_result;
      C_out    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu4_core.sv
// Self-checking bench for alu4_core: directed vectors plus 1000 random back-to-back
// operations compared against an arithmetic reference model.
module tb_alu4_core;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         C0;
  logic         S1;
  logic         S0;
  logic         M;
  logic         C_out;
  logic [W-1:0] data_out;

  int checkCount;
  int passCount;

  alu4_core #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .C0       (C0),
    .S1       (S1),
    .S0       (S0),
    .M        (M),
    .C_out    (C_out),
    .data_out (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: returns {carry, result} from plain integer arithmetic.
  function automatic logic [W:0] refModel(input int unsigned a, input int unsigned b,
                                          input int unsigned c0, input int unsigned sel,
                                          input int unsigned m);
    int unsigned mask;
    int unsigned y;
    int unsigned total;
    logic [W:0]  r;
    mask = (1 << W) - 1;
    y = 0;
    total = 0;
    if (m == 1) begin
      case (sel)
        0: y = 0;
        1: y = b;
        2: y = mask - b;
        default: y = mask;
      endcase
      total = a + y + c0;
    end else begin
      case (sel)
        0: total = a & b;
        1: total = a | b;
        2: total = a ^ b;
        default: total = mask & ~a;
      endcase
    end
    r = total[W:0];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  // Drive one operation, let one edge capture it, then sample just after the edge.
  task automatic applyStimulus(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c0, input logic [1:0] sel, input logic m);
    rst = r;
    A   = a;
    B   = b;
    C0  = c0;
    S1  = sel[1];
    S0  = sel[0];
    M   = m;
    @(posedge clk);
    #1;
  endtask

  task automatic checkCase(input string tag, input int expData, input int expCarry);
    checkOutput({tag, ".data"}, int'(data_out), expData);
    checkOutput({tag, ".cout"}, int'(C_out), expCarry);
  endtask

  logic [W:0]   expected;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         rc0;
  logic [1:0]   rsel;
  logic         rm;
  logic         rrst;

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst = 1'b1; A = '0; B = '0; C0 = 1'b0; S1 = 1'b0; S0 = 1'b0; M = 1'b0;

    // Reset dominates live operands
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0, 2'b01, 1'b1);
    checkCase("reset1", 0, 0);
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0, 2'b01, 1'b1);
    checkCase("reset2", 0, 0);
    applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b0, 2'b01, 1'b1);
    checkCase("post_reset_add", 4'b1110, 1);

    // Logic functions, with C0 both low and high
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, 4'b1100, 4'b1010, 1'(c), 2'b00, 1'b0);
      checkCase("logic_and", 4'b1000, 0);
      applyStimulus(1'b0, 4'b1100, 4'b1010, 1'(c), 2'b01, 1'b0);
      checkCase("logic_or", 4'b1110, 0);
      applyStimulus(1'b0, 4'b1100, 4'b1010, 1'(c), 2'b10, 1'b0);
      checkCase("logic_xor", 4'b0110, 0);
      applyStimulus(1'b0, 4'b1100, 4'b1010, 1'(c), 2'b11, 1'b0);
      checkCase("logic_not", 4'b0011, 0);
    end

    applyStimulus(1'b0, 4'b1100, 4'b1100, 1'b0, 2'b01, 1'b1);
    checkCase("add_carry", 4'b1000, 1);
    applyStimulus(1'b0, 4'b0011, 4'b0100, 1'b1, 2'b01, 1'b1);
    checkCase("add_cin", 4'b1000, 0);

    applyStimulus(1'b0, 4'b1001, 4'b1000, 1'b1, 2'b10, 1'b1);
    checkCase("sub_noborrow", 4'b0001, 1);
    applyStimulus(1'b0, 4'b0100, 4'b0110, 1'b1, 2'b10, 1'b1);
    checkCase("sub_borrow", 4'b1110, 0);

    applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1, 2'b11, 1'b1);
    checkCase("dec_xfer", 4'b0100, 1);
    applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b0, 2'b11, 1'b1);
    checkCase("dec", 4'b0011, 1);
    applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1, 2'b00, 1'b1);
    checkCase("inc", 4'b0101, 0);
    applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1, 2'b00, 1'b1);
    checkCase("inc_wrap", 4'b0000, 1);

    // Back-to-back random operations with occasional mid-stream reset
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc0  = 1'($urandom);
      rsel = 2'($urandom);
      rm   = 1'($urandom);
      rrst = ($urandom_range(0, 31) == 0);
      expected = rrst ? '0 : refModel(ra, rb, rc0, rsel, rm);
      applyStimulus(rrst, ra, rb, rc0, rsel, rm);
      checkCase($sformatf("rand%0d", i), int'(expected[W-1:0]), int'(expected[W]));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
